// File: rtl/vga_if.sv
// Video timing bus carrying the horizontal and vertical pixel counters.
// A frame begins on the cycle where both counters read zero.
interface vga_if #(
  parameter int CNT_W = 11
);
  logic [CNT_W-1:0] hcount;
  logic [CNT_W-1:0] vcount;

  modport master (output hcount, output vcount);
  modport slave  (input hcount, input vcount);
  modport in     (input hcount, input vcount);
endinterface

// File: rtl/card_motion_ctrl.sv
// Card-deal animator: walks a card sprite from home to a runtime target,
// one step per video frame, optionally spinning. It holds at the target
// until acknowledged, then snaps home. A stall limit forces arrival.
module card_motion_ctrl #(
  parameter int XY_W           = 12,
  parameter int STEP_W         = 4,
  parameter int X_HOME         = 252,
  parameter int Y_HOME         = 365,
  parameter int ROT_PERIOD     = 4,
  parameter int TIMEOUT_FRAMES = 255
) (
  input  logic              clk,
  input  logic              rst,
  vga_if.in                 vga_in,
  input  logic              start,
  input  logic [XY_W-1:0]   x_target,
  input  logic [XY_W-1:0]   y_target,
  input  logic [STEP_W-1:0] step,
  input  logic              spin,
  input  logic              ack,
  output logic [XY_W-1:0]   xpos,
  output logic [XY_W-1:0]   ypos,
  output logic [1:0]        angle,
  output logic              busy,
  output logic              animation_end,
  output logic              timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_FRAMES + 1);
  localparam int ROT_W = (ROT_PERIOD > 1) ? $clog2(ROT_PERIOD) : 1;

  localparam logic [XY_W-1:0]  X_H      = XY_W'(X_HOME);
  localparam logic [XY_W-1:0]  Y_H      = XY_W'(Y_HOME);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_FRAMES - 1);
  localparam logic [ROT_W-1:0] ROT_LAST = ROT_W'(ROT_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, MOVE, HOLD, RESET} state_t;

  state_t            state;
  logic [CNT_W-1:0]  frame_cnt;
  logic [ROT_W-1:0]  rot_cnt;
  logic [XY_W-1:0]   x_t;
  logic [XY_W-1:0]   y_t;
  logic [STEP_W-1:0] step_l;
  logic              spin_l;
  logic              frame_stb;
  logic              at_target;

  assign frame_stb = (vga_in.hcount == '0) && (vga_in.vcount == '0);
  assign at_target = (xpos == x_t) && (ypos == y_t);

  // Move one axis toward its target by at most stp, clamped so it never
  // overshoots and never wraps.
  function automatic logic [XY_W-1:0] step_toward(
    input logic [XY_W-1:0]   pos,
    input logic [XY_W-1:0]   tgt,
    input logic [STEP_W-1:0] stp
  );
    logic [XY_W-1:0] d;
    logic [XY_W-1:0] s;
    s = XY_W'(stp);
    if (pos < tgt) begin
      d = tgt - pos;
      return pos + ((d < s) ? d : s);
    end else begin
      d = pos - tgt;
      return pos - ((d < s) ? d : s);
    end
  endfunction

  // Capture the deal parameters on the launching strobe; a zero speed
  // would stall the card, so it is promoted to one pixel per frame.
  always_ff @(posedge clk) begin
    if (frame_stb && (state == IDLE) && start) begin
      x_t    <= x_target;
      y_t    <= y_target;
      step_l <= (step == '0) ? STEP_W'(1) : step;
      spin_l <= spin;
    end
  end

  // Deal state machine; every register advances only on a frame strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      xpos          <= X_H;
      ypos          <= Y_H;
      angle         <= 2'd0;
      frame_cnt     <= '0;
      rot_cnt       <= '0;
      busy          <= 1'b0;
      animation_end <= 1'b0;
      timeout       <= 1'b0;
    end else if (frame_stb) begin
      case (state)
        IDLE: begin
          xpos  <= X_H;
          ypos  <= Y_H;
          angle <= 2'd0;
          if (start) begin
            state     <= MOVE;
            frame_cnt <= '0;
            rot_cnt   <= '0;
            busy      <= 1'b1;
          end
        end
        MOVE: begin
          if (at_target) begin
            state         <= HOLD;
            angle         <= 2'd0;
            animation_end <= 1'b1;
          end else if (frame_cnt == CNT_LAST) begin
            state         <= HOLD;
            xpos          <= x_t;
            ypos          <= y_t;
            angle         <= 2'd0;
            timeout       <= 1'b1;
            animation_end <= 1'b1;
          end else begin
            xpos      <= step_toward(xpos, x_t, step_l);
            ypos      <= step_toward(ypos, y_t, step_l);
            frame_cnt <= frame_cnt + CNT_W'(1);
            rot_cnt   <= (rot_cnt == ROT_LAST) ? '0 : rot_cnt + ROT_W'(1);
            if (spin_l && (rot_cnt == ROT_LAST))
              angle <= angle + 2'd1;
          end
        end
        HOLD: begin
          if (ack) begin
            state <= RESET;
            xpos  <= X_H;
            ypos  <= Y_H;
            angle <= 2'd0;
          end
        end
        RESET: begin
          state         <= IDLE;
          busy          <= 1'b0;
          animation_end <= 1'b0;
          timeout       <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_card_motion_ctrl.sv
// Directed bench for card_motion_ctrl: a table of complete deals plus
// hand-written sequences for spin, timeout, async reset and handshake.
module tb_card_motion_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        spin;
  logic        ack;
  logic [11:0] x_target;
  logic [11:0] y_target;
  logic [3:0]  step;

  logic [11:0] xpos, ypos, xpos_to, ypos_to;
  logic [1:0]  angle, angle_to;
  logic        busy, animation_end, timeout;
  logic        busy_to, animation_end_to, timeout_to;

  int n_tests = 0;
  int n_fail  = 0;

  vga_if #(.CNT_W(11)) vga ();

  card_motion_ctrl dut (
    .clk(clk), .rst(rst), .vga_in(vga),
    .start(start), .x_target(x_target), .y_target(y_target),
    .step(step), .spin(spin), .ack(ack),
    .xpos(xpos), .ypos(ypos), .angle(angle),
    .busy(busy), .animation_end(animation_end), .timeout(timeout)
  );

  card_motion_ctrl #(.TIMEOUT_FRAMES(10)) dut_to (
    .clk(clk), .rst(rst), .vga_in(vga),
    .start(start), .x_target(x_target), .y_target(y_target),
    .step(step), .spin(spin), .ack(ack),
    .xpos(xpos_to), .ypos(ypos_to), .angle(angle_to),
    .busy(busy_to), .animation_end(animation_end_to), .timeout(timeout_to)
  );

  always #5 clk = ~clk;

  // Tiny raster: 4 pixels x 2 lines, so a frame strobe every 8 clocks.
  initial begin
    vga.hcount = '0;
    vga.vcount = '0;
    forever begin
      @(posedge clk);
      #1;
      if (vga.hcount == 11'd3) begin
        vga.hcount = '0;
        vga.vcount = (vga.vcount == 11'd1) ? 11'd0 : vga.vcount + 11'd1;
      end else begin
        vga.hcount = vga.hcount + 11'd1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance to just after the next strobe edge.
  task automatic frame();
    @(posedge clk);
    while (!(vga.hcount == 11'd0 && vga.vcount == 11'd0)) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    start = 1'b0; ack = 1'b0; spin = 1'b0; step = 4'd0;
    x_target = 12'd252; y_target = 12'd365;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic launch(input logic [11:0] xt, input logic [11:0] yt,
                        input logic [3:0] st, input logic sp);
    x_target = xt; y_target = yt; step = st; spin = sp;
    start = 1'b1;
    frame();
    start = 1'b0;
  endtask

  typedef struct {
    logic [11:0] xt;
    logic [11:0] yt;
    logic [3:0]  st;
    logic        sp;
    int          frames;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{xt: 12'd437, yt: 12'd452, st: 4'd2,  sp: 1'b0, frames: 94};
    vecs[1] = '{xt: 12'd437, yt: 12'd280, st: 4'd3,  sp: 1'b1, frames: 63};
    vecs[2] = '{xt: 12'd262, yt: 12'd365, st: 4'd0,  sp: 1'b0, frames: 11};
    vecs[3] = '{xt: 12'd252, yt: 12'd365, st: 4'd5,  sp: 1'b0, frames: 1};
    vecs[4] = '{xt: 12'd100, yt: 12'd50,  st: 4'd15, sp: 1'b0, frames: 22};
    vecs[5] = '{xt: 12'd0,   yt: 12'd0,   st: 4'd15, sp: 1'b1, frames: 26};

    // Reset state, observed while reset is held.
    start = 1'b0; ack = 1'b0; spin = 1'b0; step = 4'd0;
    x_target = 12'd0; y_target = 12'd0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_xpos", xpos, 252);
    check("rst_ypos", ypos, 365);
    check("rst_angle", angle, 0);
    check("rst_busy", busy, 0);
    check("rst_end", animation_end, 0);
    check("rst_timeout", timeout, 0);
    rst = 1'b0;

    // Table of complete deals.
    for (int v = 0; v < 6; v++) begin
      int n;
      do_reset();
      launch(vecs[v].xt, vecs[v].yt, vecs[v].st, vecs[v].sp);
      check($sformatf("v%0d_launch_busy", v), busy, 1);
      check($sformatf("v%0d_launch_x", v), xpos, 252);
      n = 0;
      while (!animation_end && n < 400) begin
        frame();
        n++;
      end
      check($sformatf("v%0d_frames", v), n, vecs[v].frames);
      check($sformatf("v%0d_x", v), xpos, vecs[v].xt);
      check($sformatf("v%0d_y", v), ypos, vecs[v].yt);
      check($sformatf("v%0d_angle", v), angle, 0);
      check($sformatf("v%0d_timeout", v), timeout, 0);
      check($sformatf("v%0d_busy", v), busy, 1);
    end

    // Down-right trajectory milestones.
    begin
      int bad_angle;
      bad_angle = 0;
      do_reset();
      launch(12'd437, 12'd452, 4'd2, 1'b0);
      for (int k = 1; k <= 93; k++) begin
        frame();
        if (angle != 2'd0) bad_angle++;
        if (k == 43) check("dr_y43", ypos, 451);
        if (k == 44) check("dr_y44", ypos, 452);
        if (k == 92) check("dr_x92", xpos, 436);
        if (k == 93) begin
          check("dr_x93", xpos, 437);
          check("dr_end93", animation_end, 0);
        end
      end
      frame();
      check("dr_hold", animation_end, 1);
      check("dr_angle_flight", bad_angle, 0);
    end

    // Up-deal with spin.
    begin
      int below;
      below = 0;
      do_reset();
      launch(12'd437, 12'd280, 4'd3, 1'b1);
      for (int k = 1; k <= 35; k++) begin
        frame();
        if (ypos < 12'd280) below++;
        if (k == 3)  check("sp_a3", angle, 0);
        if (k == 4)  check("sp_a4", angle, 1);
        if (k == 8)  check("sp_a8", angle, 2);
        if (k == 12) check("sp_a12", angle, 3);
        if (k == 16) check("sp_a16", angle, 0);
        if (k == 20) check("sp_a20", angle, 1);
        if (k == 10) check("sp_y10", ypos, 335);
        if (k == 29) check("sp_y29", ypos, 280);
        if (k == 35) check("sp_y35", ypos, 280);
      end
      check("sp_never_below", below, 0);
    end

    // Stall timeout on the 10-frame instance.
    do_reset();
    launch(12'd1000, 12'd365, 4'd1, 1'b0);
    repeat (9) frame();
    check("to_x9", xpos_to, 261);
    check("to_end9", animation_end_to, 0);
    check("to_flag9", timeout_to, 0);
    frame();
    check("to_x10", xpos_to, 1000);
    check("to_y10", ypos_to, 365);
    check("to_flag10", timeout_to, 1);
    check("to_end10", animation_end_to, 1);
    ack = 1'b1;
    frame();
    ack = 1'b0;
    check("to_rst_x", xpos_to, 252);
    check("to_rst_busy", busy_to, 1);
    check("to_rst_flag", timeout_to, 1);
    frame();
    check("to_idle_flag", timeout_to, 0);
    check("to_idle_busy", busy_to, 0);
    check("to_idle_end", animation_end_to, 0);
    check("to_idle_y", ypos_to, 365);

    // Asynchronous reset mid-flight.
    do_reset();
    launch(12'd437, 12'd452, 4'd2, 1'b0);
    repeat (20) frame();
    check("ar_y20", ypos, 405);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("ar_x", xpos, 252);
    check("ar_y", ypos, 365);
    check("ar_busy", busy, 0);
    check("ar_angle", angle, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    launch(12'd262, 12'd365, 4'd1, 1'b0);
    repeat (10) frame();
    check("ar_re_x", xpos, 262);
    check("ar_re_end", animation_end, 0);
    frame();
    check("ar_re_hold", animation_end, 1);

    // Handshake: start held high, stray ack pulse between strobes.
    do_reset();
    x_target = 12'd262; y_target = 12'd365; step = 4'd1; spin = 1'b0;
    start = 1'b1;
    frame();
    repeat (11) frame();
    check("hs_hold", animation_end, 1);
    repeat (3) frame();
    check("hs_hold_stays", animation_end, 1);
    check("hs_hold_x", xpos, 262);
    ack = 1'b1;
    repeat (2) @(posedge clk);
    #1 ack = 1'b0;
    frame();
    check("hs_pulse_ignored", animation_end, 1);
    check("hs_pulse_x", xpos, 262);
    ack = 1'b1;
    frame();
    ack = 1'b0;
    check("hs_reset_x", xpos, 252);
    check("hs_reset_end", animation_end, 1);
    frame();
    check("hs_idle_busy", busy, 0);
    check("hs_idle_end", animation_end, 0);
    frame();
    check("hs_relaunch_busy", busy, 1);
    check("hs_relaunch_x", xpos, 252);
    frame();
    check("hs_first_step", xpos, 253);
    start = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
